// File: rtl/fft_scale_ctrl_if.sv
// Scaling-controller bus: frame control, stage-output monitor tap and scaling results.
interface fft_scale_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SH_W   = 2,
    parameter int unsigned EXP_W  = 5
);
    logic                  frame_start;
    logic                  mon_valid;
    logic [2*DATA_W-1:0]   mon_data;
    logic                  stage_last;
    logic [SH_W-1:0]       shift_amt;
    logic                  shift_vld;
    logic [EXP_W-1:0]      blk_exp;
    logic                  busy;
    logic                  frame_done;
    logic                  ovf_err;

    modport master (
        output frame_start, mon_valid, mon_data, stage_last,
        input  shift_amt, shift_vld, blk_exp, busy, frame_done, ovf_err
    );

    modport slave (
        input  frame_start, mon_valid, mon_data, stage_last,
        output shift_amt, shift_vld, blk_exp, busy, frame_done, ovf_err
    );
endinterface

// File: rtl/fft_scale_ctrl.sv
// Block-floating-point scaling controller: tracks per-stage minimum sign headroom and
// decides the next stage's right-shift while accumulating the frame block exponent.
module fft_scale_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_STAGES = 10,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned MAX_SHIFT  = 2,
    parameter int unsigned EXP_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    fft_scale_ctrl_if.slave  ctrl_io
);
    localparam int unsigned SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int unsigned HR_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);

    typedef logic [HR_W-1:0] hr_t;
    localparam hr_t HrMax = hr_t'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StUpdate, StDone} state_e;

    // Number of bits below the MSB that repeat the sign, stopping at the first difference.
    function automatic hr_t comp_hr(input logic [DATA_W-1:0] x);
        hr_t  n;
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = int'(DATA_W) - 2; i >= 0; i--) begin
            if (run && (x[i] == x[DATA_W-1])) n = n + hr_t'(1);
            else                              run = 1'b0;
        end
        return n;
    endfunction

    state_e            state_q, state_d;
    hr_t               min_hr_q, min_hr_d;
    logic [CNT_W-1:0]  stage_cnt_q, stage_cnt_d;
    logic [SH_W-1:0]   shift_amt_q, shift_amt_d;
    logic [EXP_W-1:0]  blk_exp_q, blk_exp_d;
    logic              ovf_q, ovf_d;
    logic              shift_vld_q, shift_vld_d;

    hr_t               hr_re, hr_im, samp_hr;
    logic [SH_W-1:0]   dec_s;
    logic [EXP_W:0]    exp_sum;
    logic              exp_sat;
    int                hr_deficit;

    // Sample headroom, stage decision and saturating exponent sum.
    always_comb begin
        hr_re      = comp_hr(ctrl_io.mon_data[2*DATA_W-1:DATA_W]);
        hr_im      = comp_hr(ctrl_io.mon_data[DATA_W-1:0]);
        samp_hr    = (hr_re < hr_im) ? hr_re : hr_im;
        hr_deficit = int'(GUARD) - int'(min_hr_q);
        if (hr_deficit <= 0)                   dec_s = '0;
        else if (hr_deficit > int'(MAX_SHIFT)) dec_s = SH_W'(MAX_SHIFT);
        else                                   dec_s = SH_W'(hr_deficit);
        exp_sum = {1'b0, blk_exp_q} + (EXP_W+1)'(dec_s);
        exp_sat = exp_sum[EXP_W];
    end

    // Next-state logic; frame_start overrides every other event.
    always_comb begin
        state_d     = state_q;
        min_hr_d    = min_hr_q;
        stage_cnt_d = stage_cnt_q;
        shift_amt_d = shift_amt_q;
        blk_exp_d   = blk_exp_q;
        ovf_d       = ovf_q;
        shift_vld_d = 1'b0;
        if (ctrl_io.frame_start) begin
            state_d     = StRun;
            min_hr_d    = HrMax;
            stage_cnt_d = '0;
            shift_amt_d = '0;
            blk_exp_d   = '0;
            ovf_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    if (ctrl_io.mon_valid) begin
                        if (samp_hr < min_hr_q) min_hr_d = samp_hr;
                        if (ctrl_io.stage_last) state_d = StUpdate;
                    end
                end
                StUpdate: begin
                    shift_amt_d = dec_s;
                    blk_exp_d   = exp_sat ? {EXP_W{1'b1}} : exp_sum[EXP_W-1:0];
                    if (exp_sat) ovf_d = 1'b1;
                    shift_vld_d = 1'b1;
                    stage_cnt_d = stage_cnt_q + CNT_W'(1);
                    // A sample in this cycle already belongs to the next stage.
                    min_hr_d    = ctrl_io.mon_valid ? samp_hr : HrMax;
                    state_d     = (stage_cnt_q == CNT_W'(NUM_STAGES - 1)) ? StDone : StRun;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            min_hr_q    <= HrMax;
            stage_cnt_q <= '0;
            shift_amt_q <= '0;
            blk_exp_q   <= '0;
            ovf_q       <= 1'b0;
            shift_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_hr_q    <= min_hr_d;
            stage_cnt_q <= stage_cnt_d;
            shift_amt_q <= shift_amt_d;
            blk_exp_q   <= blk_exp_d;
            ovf_q       <= ovf_d;
            shift_vld_q <= shift_vld_d;
        end
    end

    assign ctrl_io.shift_amt  = shift_amt_q;
    assign ctrl_io.shift_vld  = shift_vld_q;
    assign ctrl_io.blk_exp    = blk_exp_q;
    assign ctrl_io.ovf_err    = ovf_q;
    assign ctrl_io.busy       = (state_q != StIdle);
    assign ctrl_io.frame_done = (state_q == StDone);
endmodule

// File: tb/tb_fft_scale_ctrl.sv
// Scoreboard bench for fft_scale_ctrl: directed stages push expected decisions,
// a negedge monitor pops one entry per shift_vld pulse.
module tb_fft_scale_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned NS = 3;
    localparam int unsigned GD = 2;
    localparam int unsigned MS = 2;
    localparam int unsigned EW = 2;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic [SW-1:0] sa;
        logic [EW-1:0] be;
        logic          ovf;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_scale_ctrl_if #(.DATA_W(DW), .SH_W(SW), .EXP_W(EW)) bus ();

    fft_scale_ctrl #(
        .DATA_W(DW), .NUM_STAGES(NS), .GUARD(GD), .MAX_SHIFT(MS), .EXP_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_io(bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   stage_id = 0;

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Drive one cycle of inputs, return just after the rising edge.
    task automatic cyc(input logic fs, input logic v, input logic [31:0] d, input logic last);
        bus.frame_start = fs;
        bus.mon_valid   = v;
        bus.mon_data    = d;
        bus.stage_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sa, input int be, input int ovf, input int done);
        exp_t e;
        e.sa   = sa[SW-1:0];
        e.be   = be[EW-1:0];
        e.ovf  = ovf[0];
        e.done = done[0];
        sb_q.push_back(e);
    endtask

    // Filler sample (headroom 13) then the stage's peak with stage_last, then the UPDATE cycle.
    task automatic stage(input logic [31:0] peak, input int sa, input int be, input int ovf,
                         input int done);
        push(sa, be, ovf, done);
        cyc(1'b0, 1'b1, 32'h0003_FFFD, 1'b0);
        cyc(1'b0, 1'b1, peak, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: every shift_vld pulse is checked against the oldest expected decision.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.shift_vld === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected shift_vld: got 1, want 0");
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("shift_amt #%0d", stage_id), int'(bus.shift_amt), int'(e.sa));
                        chk($sformatf("blk_exp #%0d", stage_id), int'(bus.blk_exp), int'(e.be));
                        chk($sformatf("ovf_err #%0d", stage_id), int'(bus.ovf_err), int'(e.ovf));
                        chk($sformatf("frame_done #%0d", stage_id), int'(bus.frame_done),
                            int'(e.done));
                        stage_id++;
                    end
                end else if (bus.frame_done === 1'b1) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame_done without shift_vld: got 1, want 0");
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.mon_valid   = 1'b0;
        bus.mon_data    = '0;
        bus.stage_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset shift_amt", int'(bus.shift_amt), 0);
        chk("reset shift_vld", int'(bus.shift_vld), 0);
        chk("reset blk_exp", int'(bus.blk_exp), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset frame_done", int'(bus.frame_done), 0);
        chk("reset ovf_err", int'(bus.ovf_err), 0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a frame.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        stage(32'h8000_0000, 2, 2, 0, 0);
        cyc(1'b0, 1'b1, 32'h0001_0001, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst shift_amt", int'(bus.shift_amt), 0);
        chk("async rst blk_exp", int'(bus.blk_exp), 0);
        chk("async rst busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 32'h8000_0000, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("idle ignores mon busy", int'(bus.busy), 0);
        chk("idle ignores mon blk_exp", int'(bus.blk_exp), 0);

        // Main three-stage frame.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("busy after frame_start", int'(bus.busy), 1);
        stage(32'h0100_0000, 0, 0, 0, 0);
        stage(32'h3000_0000, 1, 1, 0, 0);
        stage(32'h8000_0000, 2, 3, 0, 1);
        chk("busy in done", int'(bus.busy), 1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("busy after done", int'(bus.busy), 0);

        // Imag half is monitored.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        stage(32'h0000_C000, 1, 1, 0, 0);
        stage(32'h0001_0001, 0, 1, 0, 0);
        stage(32'h0000_0002, 0, 1, 0, 1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Exponent saturation and sticky overflow.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        stage(32'h8000_0000, 2, 2, 0, 0);
        stage(32'h8000_0000, 2, 3, 1, 0);
        stage(32'h8000_0000, 2, 3, 1, 1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("ovf_err sticky in idle", int'(bus.ovf_err), 1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("frame_start clears ovf_err", int'(bus.ovf_err), 0);
        chk("frame_start clears blk_exp", int'(bus.blk_exp), 0);

        // Abort during stage 1, with a stage_last sample in the restart cycle.
        stage(32'h8000_0000, 2, 2, 0, 0);
        cyc(1'b0, 1'b1, 32'h0001_0001, 1'b0);
        cyc(1'b1, 1'b1, 32'h8000_0000, 1'b1);
        chk("abort blk_exp", int'(bus.blk_exp), 0);
        chk("abort shift_amt", int'(bus.shift_amt), 0);
        chk("abort busy", int'(bus.busy), 1);
        stage(32'h0100_0000, 0, 0, 0, 0);
        stage(32'h3000_0000, 1, 1, 0, 0);
        stage(32'h0001_0001, 0, 1, 0, 1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Back-to-back stages with samples in the UPDATE cycles.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        push(0, 0, 0, 0);
        cyc(1'b0, 1'b1, 32'h0001_0001, 1'b1);
        push(2, 2, 0, 0);
        cyc(1'b0, 1'b1, 32'h4000_0000, 1'b0);
        cyc(1'b0, 1'b1, 32'h0001_0001, 1'b1);
        push(1, 3, 0, 1);
        cyc(1'b0, 1'b1, 32'h0001_0001, 1'b1);
        cyc(1'b0, 1'b1, 32'h2000_0000, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b0);

        chk("scoreboard drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
